// File: rtl/br_det_pkg.sv
// Shared RV32I control-transfer decode constants and branch class encoding.
// Imported by br_decode and branch_detector.
package br_det_pkg;

  localparam int XLEN_SUPPORTED = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_JALR    = 3'b000;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_t;

  // funct3 010/011 are the only holes in the B-type encoding space
  function automatic logic cond_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/br_decode.sv
// Combinational control-transfer decode of one instruction word: opcode and funct3 only.
// Zero latency, no flow control; the caller registers the result.
module br_decode
  import br_det_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_inst,
  output logic            o_detected,
  output br_type_t        o_type,
  output logic            o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused_bits;

  assign w_opcode      = i_inst[6:0];
  assign w_funct3      = i_inst[14:12];
  assign w_unused_bits = ^{i_inst[XLEN-1:15], i_inst[11:7]};

  always_comb begin
    o_detected = 1'b0;
    o_type     = BR_NONE;
    o_illegal  = 1'b0;
    unique case (w_opcode)
      OPC_BRANCH: begin
        if (cond_f3_legal(w_funct3)) begin
          o_detected = 1'b1;
          o_type     = BR_COND;
        end else begin
          o_illegal  = 1'b1;
        end
      end
      OPC_JAL: begin
        o_detected = 1'b1;
        o_type     = BR_JAL;
      end
      OPC_JALR: begin
        if (w_funct3 == F3_JALR) begin
          o_detected = 1'b1;
          o_type     = BR_JALR;
        end else begin
          o_illegal  = 1'b1;
        end
      end
      default: begin
        o_detected = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_detector.sv
// Registered RV32I branch/JAL/JALR detector: one-cycle latency, en=0 stalls (holds) outputs.
// Optional BR_STATS_EN adds Br_Count, a wrapping count of enabled detected cycles.
module branch_detector
  import br_det_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] Inst,
  output logic            Br_Detected,
  output logic [1:0]      Br_Type,
`ifdef BR_STATS_EN
  output logic [15:0]     Br_Count,
`endif
  output logic            Br_Illegal
);

  logic     w_detected;
  br_type_t w_type;
  logic     w_illegal;

  logic     r_detected;
  br_type_t r_type;
  logic     r_illegal;

  br_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_inst     (Inst),
    .o_detected (w_detected),
    .o_type     (w_type),
    .o_illegal  (w_illegal)
  );

  // rst wins over en so a stalled stage can still be flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_detected <= 1'b0;
      r_type     <= BR_NONE;
      r_illegal  <= 1'b0;
    end else if (en) begin
      r_detected <= w_detected;
      r_type     <= w_type;
      r_illegal  <= w_illegal;
    end
  end

  assign Br_Detected = r_detected;
  assign Br_Type     = r_type;
  assign Br_Illegal  = r_illegal;

`ifdef BR_STATS_EN
  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 16'd0;
    end else if (en && w_detected) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign Br_Count = r_count;
`endif

endmodule

// File: tb/tb_branch_detector.sv
// Self-checking bench for branch_detector: reference model plus directed vectors.
// Define BR_STATS_EN to also exercise the statistics counter.
module tb_branch_detector;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] Inst;
  logic        Br_Detected;
  logic [1:0]  Br_Type;
  logic        Br_Illegal;
`ifdef BR_STATS_EN
  logic [15:0] Br_Count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_BEQ   = 32'h00728463;
  localparam logic [31:0] I_ADD   = 32'h005282b3;
  localparam logic [31:0] I_JAL   = 32'hff5ff0ef;
  localparam logic [31:0] I_BADB  = 32'h0072a463;
  localparam logic [31:0] I_BADJR = 32'h0003a0e7;

  branch_detector #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .Inst        (Inst),
    .Br_Detected (Br_Detected),
    .Br_Type     (Br_Type),
`ifdef BR_STATS_EN
    .Br_Count    (Br_Count),
`endif
    .Br_Illegal  (Br_Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {detected, type[1:0], illegal} straight from the ISA rules
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = w[6:0];
    f3  = w[14:12];
    if (opc == 7'b1100011)
      return (f3 == 3'd2 || f3 == 3'd3) ? 4'b0_00_1 : 4'b1_01_0;
    if (opc == 7'b1101111)
      return 4'b1_10_0;
    if (opc == 7'b1100111)
      return (f3 == 3'd0) ? 4'b1_11_0 : 4'b0_00_1;
    return 4'b0_00_0;
  endfunction

  logic [3:0]  exp_out;
  logic [15:0] exp_cnt;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_out     = 4'b0;
      exp_cnt     = 16'd0;
      model_valid = 1'b1;
    end else if (en) begin
      exp_out = ref_decode(Inst);
      if (exp_out[3]) exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_det", {31'd0, Br_Detected}, {31'd0, exp_out[3]});
      chk("model_type", {30'd0, Br_Type}, {30'd0, exp_out[2:1]});
      chk("model_ill", {31'd0, Br_Illegal}, {31'd0, exp_out[0]});
`ifdef BR_STATS_EN
      chk("model_cnt", {16'd0, Br_Count}, {16'd0, exp_cnt});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input logic d, input logic [1:0] t, input logic il);
    chk({name, "_det"}, {31'd0, Br_Detected}, {31'd0, d});
    chk({name, "_type"}, {30'd0, Br_Type}, {30'd0, t});
    chk({name, "_ill"}, {31'd0, Br_Illegal}, {31'd0, il});
  endtask

  logic [31:0] seq_inst [6] = '{32'h005282b3, 32'hfe52fee3, 32'h00528333,
                                32'hff5ff0ef, 32'hf9c382e7, 32'h007302b3};
  logic        seq_det  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]  seq_type [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    Inst = 32'd0;
    repeat (2) tick();
    expect3("reset", 1'b0, 2'd0, 1'b0);

    rst  = 1'b0;
    en   = 1'b1;
    Inst = I_BEQ;
    tick();
    expect3("beq", 1'b1, 2'd1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      Inst = seq_inst[i];
      tick();
      expect3($sformatf("seq%0d", i), seq_det[i], seq_type[i], 1'b0);
    end

    Inst = I_BADB;
    tick();
    expect3("bad_branch", 1'b0, 2'd0, 1'b1);
    Inst = I_BADJR;
    tick();
    expect3("bad_jalr", 1'b0, 2'd0, 1'b1);

    // stall holds the captured beq
    Inst = I_BEQ;
    tick();
    en   = 1'b0;
    Inst = I_ADD;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect3($sformatf("hold%0d", i), 1'b1, 2'd1, 1'b0);
    end
    en = 1'b1;
    tick();
    expect3("unstall", 1'b0, 2'd0, 1'b0);

    // reset clears even while stalled
    Inst = I_JAL;
    tick();
    expect3("jal", 1'b1, 2'd2, 1'b0);
    en  = 1'b0;
    rst = 1'b1;
    tick();
    expect3("rst_stalled", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    expect3("jal2", 1'b1, 2'd2, 1'b0);

    // reset pulse between edges is not sampled
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    expect3("midpulse", 1'b1, 2'd2, 1'b0);
    tick();
    expect3("after_pulse", 1'b1, 2'd2, 1'b0);

`ifdef BR_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Inst = (i % 3 == 1) ? I_ADD : I_BEQ;
      tick();
    end
    chk("count5", {16'd0, Br_Count}, 32'd5);
    en   = 1'b0;
    Inst = I_BEQ;
    tick();
    chk("count_hold", {16'd0, Br_Count}, 32'd5);

    en  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    chk("count_ffff", {16'd0, Br_Count}, 32'h0000ffff);
    tick();
    chk("count_wrap", {16'd0, Br_Count}, 32'd0);
`endif

    Inst = I_ADD;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_detector.md
Name: branch_detector

Overview:
- Pipeline-front helper for the RV32I pipeline. Inspects the 32-bit instruction word each cycle and flags control-transfer instructions: conditional branch, JAL, JALR.
- Result is registered (one-cycle latency) so hazard/flush logic sees a stable flag in the following stage.
- Also reports a 2-bit branch class and an illegal-encoding flag for malformed branch/JALR words.

Parameters:
- XLEN, 32, instruction width; only 32 supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  stage enable; 0 holds all registered outputs (pipeline stall).
- Inst  input  32  instruction word from fetch.
- Br_Detected  output  1  registered: 1 when the captured Inst is a legal B-type, JAL or JALR.
- Br_Type  output  2  registered class: 0 none, 1 conditional, 2 JAL, 3 JALR.
- Br_Illegal  output  1  registered: opcode is branch/JALR but funct3 is invalid.

Behaviour:
- Decode is combinational on Inst[6:0] (opcode) and Inst[14:12] (funct3).
- Conditional branch: opcode 7'b1100011 with funct3 in {000,001,100,101,110,111} -> detected, type 1.
- Conditional branch with funct3 010 or 011 -> not detected, type 0, illegal 1.
- JAL: opcode 7'b1101111, any funct3 -> detected, type 2.
- JALR: opcode 7'b1100111 with funct3 000 -> detected, type 3.
- JALR with funct3 != 000 -> not detected, type 0, illegal 1.
- Any other opcode -> detected 0, type 0, illegal 0.
- Registers update on each rising clk edge when en=1; latency exactly one cycle from Inst to outputs.
- rst=1 at a clock edge forces Br_Detected=0, Br_Type=0, Br_Illegal=0. rst has priority over en.
- Reset is synchronous: asserting rst between edges has no effect until the next edge.
- en=0 holds the previous values. rst with en=0 still clears.
- Inst containing X/Z is not sanitized; it is the upstream stage's responsibility.
- No internal state beyond the output registers (plus the optional counter).

Optional Feature:
- Macro BR_STATS_EN.
- Defined: adds output Br_Count[15:0], a registered count of cycles where en=1 and the decode is detected. Cleared by rst; wraps from 16'hFFFF to 0; held when en=0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package br_det_pkg holds:
  - opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111;
  - enum br_type_t {BR_NONE, BR_COND, BR_JAL, BR_JALR} (2 bits).
- One natural sub-module, br_decode: purely combinational Inst -> {detected, type, illegal}. The top wraps it with the enable/reset registers and the optional counter.

Test Plan:
- rst=1 for 2 cycles, then Inst=32'h00728463 (beq) with en=1 -> after one edge Br_Detected=1, Br_Type=1, Br_Illegal=0.
- Sequence 005282b3 (add), fe52fee3 (bgeu), 00528333 (add), ff5ff0ef (jal), f9c382e7 (jalr), 007302b3 (add), one per cycle -> Br_Detected 0,1,0,1,1,0 and Br_Type 0,1,0,2,3,0, each one cycle after its Inst.
- Inst=32'h0072a463 (branch, funct3 010) -> Br_Detected=0, Br_Illegal=1. Inst=32'h0003a0e7 (jalr, funct3 010) -> Br_Detected=0, Br_Illegal=1.
- Hold beq with en=1 for one edge, then en=0 and Inst=add for 3 cycles -> outputs stay 1/1/0. Set en=1 -> outputs clear on the next edge.
- Detected state, then assert rst with en=0 -> all outputs 0 after the next edge. Pulse rst mid-cycle without a clock edge -> outputs unchanged.
- With BR_STATS_EN: 5 branch cycles interleaved with 3 non-branch cycles -> Br_Count=5. Preload by driving 65536 branch cycles -> Br_Count wraps to 0.
